// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational 8x8 multiplier among NUM_REQ requesters.
// Optional build macro MULT_ZERO_SKIP_EN: zero-operand requests bypass the multiplier and answer in one cycle.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_lop,
  input  logic [NUM_REQ*8-1:0] req_rop,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           mul_lop,
  output logic [7:0]           mul_rop,
  input  logic [31:0]          mul_oval,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready,
  output logic [1:0]           state_dbg
);

  // Request side:  transfer when req_valid[i] && req_ready[i]; req_ready is only ever high in IDLE.
  // Response side: transfer when rsp_valid && rsp_ready; rsp_* are stable while rsp_valid && !rsp_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] grant_id;
  logic            found;
  logic [7:0]      sel_lop;
  logic [7:0]      sel_rop;
  logic            accept;
  logic            skip;
  int              idx;

  // Priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    sel_lop  = '0;
    sel_rop  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
        sel_lop  = req_lop[idx*8 +: 8];
        sel_rop  = req_rop[idx*8 +: 8];
      end
    end
  end

  assign accept = (state == IDLE) && found;

`ifdef MULT_ZERO_SKIP_EN
  assign skip = accept && ((sel_lop == 8'd0) || (sel_rop == 8'd0));
`else
  assign skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = skip ? RESP : EXEC;
      EXEC: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NUM_REQ'(1) << grant_id;
  end

  assign state_dbg = state;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      id_reg    <= '0;
      mul_lop   <= '0;
      mul_rop   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          if (skip) begin
            rsp_data  <= '0;
            rsp_id    <= grant_id;
            rsp_valid <= 1'b1;
          end else begin
            mul_lop <= sel_lop;
            mul_rop <= sel_rop;
            id_reg  <= grant_id;
          end
        end
        EXEC: begin
          rsp_data  <= mul_oval;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural model of the shared 8x8 multiplier.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_lop;
  logic [31:0] req_rop;
  logic [3:0]  req_ready;
  logic [7:0]  mul_lop;
  logic [7:0]  mul_rop;
  logic [31:0] mul_oval;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_lop(req_lop), .req_rop(req_rop), .req_ready(req_ready),
    .mul_lop(mul_lop), .mul_rop(mul_rop), .mul_oval(mul_oval),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .state_dbg(state_dbg)
  );

  // CombMultiplier8 model
  assign mul_oval = {16'b0, 16'(mul_lop) * 16'(mul_rop)};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One full op with req_valid held at mask and rsp_ready=1.
  task automatic run_op(input string tag, input logic [3:0] mask, input logic [1:0] g,
                        input logic [31:0] p);
    req_valid = mask;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << g));
    tick();
    check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(g));
    check({tag, "_rsp_data"}, rsp_data, p);
    tick();
    check({tag, "_drain"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_lop = '0; req_rop = '0; rsp_ready = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_mul_lop", 32'(mul_lop), 32'd0);
    check("rst_mul_rop", 32'(mul_rop), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single requester 5*3
    req_lop = {8'd0, 8'd0, 8'd0, 8'd5};
    req_rop = {8'd0, 8'd0, 8'd0, 8'd3};
    req_valid = 4'b0001;
    #1;
    check("t1_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check("t1_state_exec", 32'(state_dbg), 32'd1);
    check("t1_mul_lop", 32'(mul_lop), 32'd5);
    check("t1_mul_rop", 32'(mul_rop), 32'd3);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_data", rsp_data, 32'd15);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_drain", 32'(rsp_valid), 32'd0);
    check("t1_idle", 32'(state_dbg), 32'd0);

    // 2: req 1 and 2 contend, rr_ptr=1
    req_lop = {8'd0, 8'd20, 8'd45, 8'd0};
    req_rop = {8'd0, 8'd5, 8'd13, 8'd0};
    run_op("t2a", 4'b0110, 2'd1, 32'd585);
    run_op("t2b", 4'b0100, 2'd2, 32'd100);
    // rr_ptr=3 means req 3 beats req 0
    req_lop = {8'd10, 8'd0, 8'd0, 8'd1};
    req_rop = {8'd10, 8'd0, 8'd0, 8'd1};
    run_op("t2_rr3", 4'b1001, 2'd3, 32'd100);

    // 3: all requesters valid, rr_ptr=0
    req_lop = {8'd4, 8'd3, 8'd2, 8'd1};
    req_rop = {8'd40, 8'd30, 8'd20, 8'd10};
    run_op("t3_0", 4'b1111, 2'd0, 32'd10);
    run_op("t3_1", 4'b1111, 2'd1, 32'd40);
    run_op("t3_2", 4'b1111, 2'd2, 32'd90);
    run_op("t3_3", 4'b1111, 2'd3, 32'd160);
    run_op("t3_4", 4'b1111, 2'd0, 32'd10);
    run_op("t3_5", 4'b1111, 2'd1, 32'd40);
    run_op("t3_6", 4'b1111, 2'd2, 32'd90);
    run_op("t3_7", 4'b1111, 2'd3, 32'd160);

    // 4: backpressure on 255*255
    rsp_ready = 1'b0;
    req_lop = {8'd0, 8'd0, 8'd6, 8'd255};
    req_rop = {8'd0, 8'd0, 8'd7, 8'd255};
    req_valid = 4'b0001;
    #1;
    check("t4_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    tick();
    check("t4_rsp_data", rsp_data, 32'd65025);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_data", rsp_data, 32'd65025);
      check("t4_hold_id", 32'(rsp_id), 32'd0);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4_resume_grant", 32'(req_ready), 32'b0010);
    check("t4_released", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 4'b0000;
    tick();
    check("t4b_rsp_id", 32'(rsp_id), 32'd1);
    check("t4b_rsp_data", rsp_data, 32'd42);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 5: reset during EXEC
    req_lop = {8'd2, 8'd0, 8'd0, 8'd7};
    req_rop = {8'd2, 8'd0, 8'd0, 8'd9};
    req_valid = 4'b0001;
    #1;
    check("t5_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("t5_exec", 32'(state_dbg), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_state", 32'(state_dbg), 32'd0);
    check("t5_rst_mul_lop", 32'(mul_lop), 32'd0);
    tick();
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("t5_no_rsp2", 32'(rsp_valid), 32'd0);
    run_op("t5_req3", 4'b1000, 2'd3, 32'd4);

    // 6: zero operand
    req_lop = {8'd0, 8'd0, 8'd0, 8'd0};
    req_rop = {8'd0, 8'd0, 8'd0, 8'd77};
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    check("t6_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
`ifdef MULT_ZERO_SKIP_EN
    check("t6_skip_valid", 32'(rsp_valid), 32'd1);
    check("t6_skip_data", rsp_data, 32'd0);
    check("t6_skip_id", 32'(rsp_id), 32'd0);
    check("t6_skip_mul_lop", 32'(mul_lop), 32'd2);
    check("t6_skip_mul_rop", 32'(mul_rop), 32'd2);
`else
    check("t6_exec_valid", 32'(rsp_valid), 32'd0);
    check("t6_mul_lop", 32'(mul_lop), 32'd0);
    check("t6_mul_rop", 32'(mul_rop), 32'd77);
    tick();
    check("t6_valid", 32'(rsp_valid), 32'd1);
    check("t6_data", rsp_data, 32'd0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t6_drain", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares one external CombMultiplier8 instance (8-bit lop/rop, 32-bit oval, purely combinational) between NUM_REQ requesters. Each requester uses a valid/ready request handshake. Accepted operands are registered onto the multiplier inputs, and the product is captured into a one-entry response buffer. The response buffer carries the requester ID and is drained through a valid/ready response handshake. The block sits between PE-side operand sources and the shared multiplier.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_lop  input  NUM_REQ*8  packed left operands; requester i at bits [8i+7:8i]
req_rop  input  NUM_REQ*8  packed right operands, same packing
req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high
mul_lop  output  8  registered left operand to CombMultiplier8
mul_rop  output  8  registered right operand to CombMultiplier8
mul_oval  input  32  product from CombMultiplier8
rsp_valid  output  1  response buffer holds a result
rsp_id  output  ID_W  requester index of the result
rsp_data  output  32  product
rsp_ready  input  1  consumer accepts the response

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, mul_lop=0, mul_rop=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0.
- States:
  - IDLE: no operation in flight.
  - EXEC: operands on mul_lop/rop; multiplier settling.
  - RESP: rsp_valid=1, waiting for rsp_ready.
- Arbitration (IDLE only):
  - Scan req_valid starting at rr_ptr, ascending, wrapping mod NUM_REQ. First set bit g is granted.
  - req_ready[g]=1 combinationally in the same cycle. req_ready is all-zero in EXEC and RESP.
  - Handshake occurs when req_valid[g] && req_ready[g].
- Accept edge (from IDLE):
  - mul_lop<=req_lop[g], mul_rop<=req_rop[g], id_reg<=g.
  - rr_ptr<=(g+1) mod NUM_REQ; state<=EXEC.
- EXEC, next edge: rsp_data<=mul_oval, rsp_id<=id_reg, rsp_valid<=1, state<=RESP. mul_lop/rop hold their value.
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, state<=IDLE.
  - No accept in the same cycle. Re-arbitration happens in the following IDLE cycle.
- Latency: accept at edge T, rsp_valid high after edge T+1 (2 cycles, request to response). Best-case throughput is one op per 3 cycles.
- rr_ptr changes only on accept. Idle cycles leave it unchanged.
- Requesters must hold req_lop/rop stable while req_valid is high. Dropping req_valid without a handshake is legal and simply loses arbitration.
- Products are zero-extended: oval = {16'b0, lop*rop}. Maximum is 255*255=65025.
- Reset asserted in any state: the in-flight operation is discarded with no response, and all registers return to reset values on that edge.
- No requester is granted twice in a row while another is valid (starvation bound: NUM_REQ-1 ops).

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: at accept, if req_lop[g]==0 or req_rop[g]==0, skip EXEC. Go IDLE->RESP directly with rsp_data=0, giving latency 1 cycle. mul_lop/rop are not updated on a skipped op, to save multiplier toggling.
- Undefined: every op takes the EXEC path.
- Arbitration and rr_ptr update are identical in both builds.

Test Plan:
1. Reset, then only req 0 valid with lop=5, rop=3 -> req_ready=4'b0001 the same cycle; rsp_valid high 2 cycles after accept with rsp_id=0, rsp_data=15.
2. req 1 and req 2 valid simultaneously (45*13, 20*5), rsp_ready=1 -> grants in order 1 then 2; responses (id1, 585) then (id2, 100); rr_ptr=3 after.
3. All 4 requesters held valid for 8 ops with rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; req_ready never multi-hot.
4. rsp_ready=0 for 5 cycles after response 255*255 -> rsp_data=65025 held stable, req_ready=0 throughout; accept resumes the cycle after rsp_ready pulses.
5. reset asserted during EXEC of 7*9 -> no rsp_valid appears; next op 2*2 from req 3 is granted first, since rr_ptr=0 and req 0 is not valid; returns 4.
6. MULT_ZERO_SKIP_EN defined, lop=0, rop=77 -> rsp_valid after 1 cycle, rsp_data=0, mul_lop/rop unchanged. Undefined -> 2 cycles, rsp_data=0.
